hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have parameter MULDIV_LAT, default 32, giving the mult/div busy cycles after issue (legal range 2..63).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the performance counter width.
REQ-003 The block SHALL have one clock, clk, with reset rst_n asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ID_EX_MemRead  in  1  the EX-stage instruction is a load.
REQ-007 ID_EX_rd  in  5  EX-stage destination register.
REQ-008 EX_MEM_MemRead  in  1  the MEM-stage instruction is a load.
REQ-009 EX_MEM_rd  in  5  MEM-stage destination register.
REQ-010 IF_ID_rs, IF_ID_rt  in  5 each  ID-stage source registers.
REQ-011 ID_uses_rt  in  1  the ID instruction reads rt.
REQ-012 ID_is_branch  in  1  the ID instruction is a conditional branch resolved in ID.
REQ-013 ID_redirect  in  1  a branch is taken or a jump is in ID this cycle.
REQ-014 ID_is_muldiv  in  1  the ID instruction is mult/div.
REQ-015 ID_reads_hilo  in  1  the ID instruction is mfhi/mflo.
REQ-016 ext_stall  in  1  memory-system freeze request.
REQ-017 PCWrite, IF_ID_Write  out  1 each  PC and IF/ID register enables.
REQ-018 IF_ID_Flush, ID_EX_Flush  out  1 each  bubble inserts.
REQ-019 muldiv_busy  out  1  mult/div unit is occupied.
REQ-020 stall_cycles, flush_count  out  CNT_W each  performance counters.

Function
REQ-021 load_use SHALL be ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==IF_ID_rs || (ID_uses_rt && ID_EX_rd==IF_ID_rt)).
REQ-022 br_mem_load SHALL be ID_is_branch && EX_MEM_MemRead && EX_MEM_rd!=0 && EX_MEM_rd matches IF_ID_rs, or matches IF_ID_rt when ID_uses_rt is set.
REQ-023 A branch depending on an EX-stage load SHALL stall 2 cycles: cycle 1 via load_use, cycle 2 via br_mem_load.
REQ-024 ALU results in EX or MEM SHALL NOT cause a stall, because ID forwarding covers them.
REQ-025 md_hazard SHALL be muldiv_busy && (ID_is_muldiv || ID_reads_hilo).
REQ-026 hz_stall SHALL be load_use || br_mem_load || md_hazard.
REQ-027 When hz_stall is set and ext_stall is clear: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
REQ-028 When ext_stall is set: PCWrite=0, IF_ID_Write=0, and both flushes=0, overriding all hazards.
REQ-029 When neither stall is active: PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=ID_redirect.
REQ-030 A redirect coinciding with any stall SHALL be suppressed; it takes effect in the first non-stall cycle.
REQ-031 All four control outputs SHALL be combinational from current inputs and the registered busy counter.
REQ-032 md_cnt (6 bits) SHALL load MULDIV_LAT on the clk edge where ID_is_muldiv && !hz_stall && !ext_stall.
REQ-033 Otherwise md_cnt SHALL decrement by 1 when nonzero, including during ext_stall, and hold at 0.
REQ-034 muldiv_busy SHALL be (md_cnt!=0), registered.
REQ-035 Issue: a mult issued at edge N drives busy high over cycles N+1..N+MULDIV_LAT.
REQ-036 stall_cycles SHALL increment on each edge where hz_stall || ext_stall, and saturate at all-ones.
REQ-037 flush_count SHALL increment on each edge where IF_ID_Flush=1, and saturate at all-ones.

Reset
REQ-038 While rst_n=0, all registers SHALL clear immediately: md_cnt=0, muldiv_busy=0, stall_cycles=0, flush_count=0.
REQ-039 While rst_n=0, outputs SHALL follow REQ-027..029 from the cleared state.
REQ-040 A reset mid-mult/div SHALL abandon the busy window; the first post-reset mfhi SHALL NOT stall.

Verification
REQ-041 Load-use: ID_EX_MemRead=1, ID_EX_rd=8, IF_ID_rs=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, stall_cycles 0->1.
REQ-042 Load then beq: cycle 1 ID_EX_rd=9 load, beq rt=9, ID_uses_rt=1; cycle 2 EX_MEM_rd=9 load -> 2 stall cycles, then PCWrite=1.
REQ-043 rd=0: load with ID_EX_rd=0, IF_ID_rs=0 -> no stall, PCWrite=1.
REQ-044 Mult then mfhi: mult issued at edge 0, mfhi in ID next -> stalls exactly 32 cycles, then proceeds; busy falls after 32 edges.
REQ-045 Priority: ID_redirect=1 with load_use=1 -> IF_ID_Flush=0, ID_EX_Flush=1; next non-stall cycle with redirect -> IF_ID_Flush=1, flush_count+1.
REQ-046 Saturation and reset: preload via 65535 stall cycles -> stall_cycles holds at 0xFFFF; assert rst_n=0 mid-busy -> all counters 0 asynchronously.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline hazard signals between datapath and stall unit
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rd;
  logic             EX_MEM_MemRead;
  logic [4:0]       EX_MEM_rd;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             ID_uses_rt;
  logic             ID_is_branch;
  logic             ID_redirect;
  logic             ID_is_muldiv;
  logic             ID_reads_hilo;
  logic             ext_stall;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: supplies stage info, consumes enables/flushes
  modport master (
    output ID_EX_MemRead, ID_EX_rd, EX_MEM_MemRead, EX_MEM_rd,
    output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_is_branch, ID_redirect,
    output ID_is_muldiv, ID_reads_hilo, ext_stall,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    input  muldiv_busy, stall_cycles, flush_count
  );

  // Stall unit side
  modport slave (
    input  ID_EX_MemRead, ID_EX_rd, EX_MEM_MemRead, EX_MEM_rd,
    input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_is_branch, ID_redirect,
    input  ID_is_muldiv, ID_reads_hilo, ext_stall,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    output muldiv_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch/mult-div hazard stall and flush control
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
);

  localparam logic [5:0]       MD_LAT   = 6'(MULDIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [5:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_busy;
  logic w_load_use;
  logic w_br_mem_load;
  logic w_md_hazard;
  logic w_hz_stall;
  logic w_any_stall;
  logic w_md_issue;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  assign w_busy = (r_md_cnt != 6'd0);

  // Hazard detection; ALU producers are covered by ID forwarding and never stall
  always_comb begin
    w_load_use = bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
                 ((bus.ID_EX_rd == bus.IF_ID_rs) ||
                  (bus.ID_uses_rt && (bus.ID_EX_rd == bus.IF_ID_rt)));
    w_br_mem_load = bus.ID_is_branch && bus.EX_MEM_MemRead && (bus.EX_MEM_rd != 5'd0) &&
                    ((bus.EX_MEM_rd == bus.IF_ID_rs) ||
                     (bus.ID_uses_rt && (bus.EX_MEM_rd == bus.IF_ID_rt)));
    w_md_hazard = w_busy && (bus.ID_is_muldiv || bus.ID_reads_hilo);
    w_hz_stall  = w_load_use || w_br_mem_load || w_md_hazard;
    w_any_stall = w_hz_stall || bus.ext_stall;
    w_md_issue  = bus.ID_is_muldiv && !w_hz_stall && !bus.ext_stall;
  end

  // Pipeline control: ext_stall freezes everything, a hazard bubbles EX, redirect waits for a free cycle
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (bus.ext_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
    end else if (w_hz_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end else begin
      w_if_id_flush = bus.ID_redirect;
    end
  end

  // Mult/div busy window: reload on issue, otherwise count down to zero even while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= 6'd0;
    end else if (w_md_issue) begin
      r_md_cnt <= MD_LAT;
    end else if (r_md_cnt != 6'd0) begin
      r_md_cnt <= r_md_cnt - 6'd1;
    end
  end

  // Saturating count of cycles lost to any stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_any_stall && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

  // Saturating count of IF/ID flushes actually applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_count <= '0;
    end else if (w_if_id_flush && (r_flush_count != CNT_MAX)) begin
      r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign bus.PCWrite      = w_pc_write;
  assign bus.IF_ID_Write  = w_if_id_write;
  assign bus.IF_ID_Flush  = w_if_id_flush;
  assign bus.ID_EX_Flush  = w_id_ex_flush;
  assign bus.muldiv_busy  = w_busy;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule
